// File: rtl/bridge_timer.sv
// Memory-mapped programmable down-counter for the bridge bus, with one-shot and auto-reload modes.
// Latency: register writes take effect at the write edge; DOut is combinational; IRQ is registered.
// Backpressure: none; every bus write is accepted in the cycle WE is high.
module bridge_timer #(
    parameter logic [31:0] CTRL_MASK = 32'h0000_000F,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    state_t             state_q, state_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q, flag_d;
    logic               irq_q, irq_d;

    logic               en;
    logic               auto_mode;
    logic               flag_set;
    logic [31:0]        count_ext;
    logic [31:0]        preset_ext;

    assign en        = ctrl_q[0];
    assign auto_mode = (ctrl_q[2:1] == MODE_AUTO);

    // Next-state: FSM step first, then bus writes override CTRL/PRESET, and the FSM flag set beats a CTRL-write clear
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        flag_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = CNT;
                end
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // PRESET of 0 lands here too and saturates at 0 rather than wrapping
                    count_d  = '0;
                    flag_set = 1'b1;
                    state_d  = INT;
                end
            end
            INT: begin
                if (auto_mode) begin
                    flag_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (WE) begin
            case (Addr)
                ADDR_CTRL: begin
                    ctrl_d = DIn & CTRL_MASK;
                    flag_d = 1'b0;
                end
                ADDR_PRESET: begin
                    preset_d = DIn[CNT_W-1:0];
                end
                default: begin
                end
            endcase
        end

        if (flag_set) begin
            flag_d = 1'b1;
        end

        // IRQ is registered from next-state values so it rises together with entry into INT
        irq_d = flag_d & ctrl_d[3];
    end

    // State registers with synchronous active-low reset that overrides any bus write
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-extend the counter registers to the 32-bit read path
    always_comb begin
        count_ext              = '0;
        preset_ext             = '0;
        count_ext[CNT_W-1:0]   = count_q;
        preset_ext[CNT_W-1:0]  = preset_q;
    end

    // Read mux; the reserved address reads 0
    always_comb begin
        case (Addr)
            ADDR_CTRL:   DOut = ctrl_q;
            ADDR_PRESET: DOut = preset_ext;
            ADDR_COUNT:  DOut = count_ext;
            default:     DOut = 32'd0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are sampled in the same window.
// All comparisons go through check_eq.
module tb_bridge_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int n_vec;
    int n_miss;

    bridge_timer dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check_eq(tag, DOut, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check_eq(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        int pulses;
        int found;
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        WE     = 1'b1;
        Addr   = 2'd0;
        DIn    = 32'hF;

        // Reset held with a competing CTRL write
        step();
        step();
        reset = 1'b1;
        WE    = 1'b0;
        chk_irq("rst_irq", 1'b0);
        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_preset", 2'd1, 32'h0);
        rd("rst_count", 2'd2, 32'h0);
        rd("rst_rsvd", 2'd3, 32'h0);

        // One-shot, PRESET=3; CTRL write is edge t
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'h9);
        step();                                   // t+1 LOAD
        rd("os_load_cnt", 2'd2, 32'd0);
        step(); rd("os_cnt3", 2'd2, 32'd3); chk_irq("os_irq_t2", 1'b0);
        step(); rd("os_cnt2", 2'd2, 32'd2);
        step(); rd("os_cnt1", 2'd2, 32'd1); chk_irq("os_irq_t4", 1'b0);
        step(); rd("os_cnt0", 2'd2, 32'd0); chk_irq("os_irq_t5", 1'b1);
        step(); rd("os_ctrl_en_clr", 2'd0, 32'h8); chk_irq("os_irq_hold", 1'b1);
        step(); chk_irq("os_irq_hold2", 1'b1);
        bus_wr(2'd0, 32'h0);
        chk_irq("os_irq_cleared", 1'b0);

        // Auto-reload, PRESET=2: INT at t+4k, COUNT 2,1,0,0 from t+2
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'hB);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] ec;
            step();
            if (k == 1) ec = 32'd0;
            else begin
                case ((k - 2) % 4)
                    0: ec = 32'd2;
                    1: ec = 32'd1;
                    default: ec = 32'd0;
                endcase
            end
            rd($sformatf("ar_cnt_k%0d", k), 2'd2, ec);
            chk_irq($sformatf("ar_irq_k%0d", k), (k % 4) == 0);
            if (IRQ) pulses++;
        end
        check_eq("ar_pulses", pulses, 32'd5);
        bus_wr(2'd0, 32'h0);
        step();
        step();

        // Pause/resume, PRESET=10; CTRL write is edge t, COUNT=7 at t+5
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'h9);
        for (int k = 0; k < 5; k++) step();
        rd("pr_cnt7", 2'd2, 32'd7);
        bus_wr(2'd0, 32'h8);                      // lands on the edge producing 6
        rd("pr_cnt6", 2'd2, 32'd6);
        for (int k = 0; k < 5; k++) begin
            step();
            rd($sformatf("pr_hold_%0d", k), 2'd2, 32'd6);
        end
        bus_wr(2'd0, 32'h9);
        step(); rd("pr_load_cnt", 2'd2, 32'd6);
        step(); rd("pr_reload10", 2'd2, 32'd10);

        // PRESET write during CNT, then switch to auto-reload
        bus_wr(2'd1, 32'd7);
        rd("pw_cnt9", 2'd2, 32'd9);
        rd("pw_preset7", 2'd1, 32'd7);
        bus_wr(2'd0, 32'hB);
        rd("pw_cnt8", 2'd2, 32'd8);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (IRQ) begin
                found = 1;
                break;
            end
        end
        check_eq("pw_int_seen", found, 32'd1);
        rd("pw_int_cnt0", 2'd2, 32'd0);
        step();
        step();
        rd("pw_reload7", 2'd2, 32'd7);
        bus_wr(2'd0, 32'h0);                      // FSM still sees EN=1 at this edge
        rd("pw_stop_cnt", 2'd2, 32'd6);
        step();

        // Writes to COUNT and reserved address are ignored
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        rd("ro_cnt", 2'd2, 32'd6);
        rd("ro_ctrl", 2'd0, 32'h0);
        rd("ro_preset", 2'd1, 32'd7);
        rd("ro_rsvd", 2'd3, 32'h0);

        // PRESET=0 behaves as 1: IRQ three cycles after the CTRL write
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd0, 32'h9);
        step();
        step(); rd("p0_cnt", 2'd2, 32'd0); chk_irq("p0_irq_t2", 1'b0);
        step(); chk_irq("p0_irq_t3", 1'b1);

        // Collision: CTRL=9 written in the INT cycle
        bus_wr(2'd0, 32'h9);
        rd("col_ctrl", 2'd0, 32'h9);
        chk_irq("col_irq_drop", 1'b0);
        step(); chk_irq("col_load_irq", 1'b0);
        step(); rd("col_cnt", 2'd2, 32'd0);
        step(); chk_irq("col_int_again", 1'b1);
        step(); rd("col_ctrl_after", 2'd0, 32'h8);

        // IM=0: flag sets but IRQ stays low
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd0, 32'h1);
        chk_irq("im0_clr", 1'b0);
        step();
        step(); rd("im0_cnt1", 2'd2, 32'd1);
        step(); chk_irq("im0_int_masked", 1'b0);
        step(); rd("im0_ctrl", 2'd0, 32'h0);

        // Reset mid-count with a competing write
        bus_wr(2'd1, 32'd5);
        bus_wr(2'd0, 32'h9);
        step(); step(); step();
        rd("mr_cnt4", 2'd2, 32'd4);
        reset = 1'b0;
        WE    = 1'b1;
        Addr  = 2'd0;
        DIn   = 32'hF;
        step();
        reset = 1'b1;
        WE    = 1'b0;
        rd("mr_cnt", 2'd2, 32'd0);
        rd("mr_ctrl", 2'd0, 32'h0);
        chk_irq("mr_irq", 1'b0);
        step();
        rd("mr_idle_cnt", 2'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
